sat_accum_pipe: RTL and testbench

Parametrised, registered successor to the team's combinational 8-bit signed saturating adder.
- Accepts a stream of signed operand pairs over a valid/ready handshake.
- Performs saturating add, subtract or accumulate; also supports clearing the accumulator.
- Returns a registered result with per-result overflow/underflow flags, a sticky saturation flag and a saturating event counter.
- Sits between a sample source and downstream DSP logic that must never see wrapped values.

---
 rtl/sat_pkg.sv | 13 +
 rtl/sat_addsub_core.sv | 37 +++
 rtl/sat_accum_pipe.sv | 139 +++++++++++++
 tb/tb_sat_accum_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
// Shared operation encoding for the saturating accumulator pipeline.
package sat_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

endpackage

// File: rtl/sat_addsub_core.sv
// Combinational signed saturating add/subtract at WIDTH bits.
module sat_addsub_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] res,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] x_ext;
  logic [WIDTH:0] y_ext;
  logic [WIDTH:0] raw;

  // One guard bit holds any sum/difference of two WIDTH-bit values exactly,
  // so a disagreement between the top two bits means the result left range.
  always_comb begin
    x_ext = {x[WIDTH-1], x};
    y_ext = {y[WIDTH-1], y};
    raw   = sub ? (x_ext - y_ext) : (x_ext + y_ext);
    ovf   = !raw[WIDTH] &&  raw[WIDTH-1];
    unf   =  raw[WIDTH] && !raw[WIDTH-1];
    if (ovf) begin
      res = MAX;
    end else if (unf) begin
      res = MIN;
    end else begin
      res = raw[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/sat_accum_pipe.sv
// Registered saturating add/sub/accumulate stage with valid/ready handshake
// and saturation statistics.
module sat_accum_pipe
  import sat_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_ovf,
  output logic             out_unf,
  output logic [WIDTH-1:0] acc_q,
  output logic             sticky_sat,
  output logic [CNT_W-1:0] sat_cnt,
  input  logic             clr_stat
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_res_q, out_res_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_unf_q, out_unf_d;
  logic [WIDTH-1:0] acc_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  op_e              op;
  logic             in_fire;
  logic             out_fire;
  logic             sat_ev;
  logic [WIDTH-1:0] core_x;
  logic [WIDTH-1:0] core_y;
  logic             core_sub;
  logic [WIDTH-1:0] core_res;
  logic             core_ovf;
  logic             core_unf;

  assign in_ready = !out_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // Operand select: ACC feeds the accumulator through the same adder.
  always_comb begin
    op       = op_e'(in_op);
    core_x   = (op == OP_ACC) ? acc_q : in_a;
    core_y   = (op == OP_ACC) ? in_a  : in_b;
    core_sub = (op == OP_SUB);
  end

  sat_addsub_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .x   (core_x),
    .y   (core_y),
    .sub (core_sub),
    .res (core_res),
    .ovf (core_ovf),
    .unf (core_unf)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    out_ovf_d   = out_ovf_q;
    out_unf_d   = out_unf_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    sat_ev      = in_fire && (op != OP_CLR) && (core_ovf || core_unf);

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    // A new accept overrides the drain so throughput stays one per cycle.
    if (in_fire) begin
      out_valid_d = 1'b1;
      if (op == OP_CLR) begin
        out_res_d = '0;
        out_ovf_d = 1'b0;
        out_unf_d = 1'b0;
        acc_d     = '0;
      end else begin
        out_res_d = core_res;
        out_ovf_d = core_ovf;
        out_unf_d = core_unf;
        if (op == OP_ACC) begin
          acc_d = core_res;
        end
      end
    end

    if (clr_stat) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (sat_ev) begin
      sticky_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_ovf_q   <= out_ovf_d;
      out_unf_q   <= out_unf_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_res    = out_res_q;
  assign out_ovf    = out_ovf_q;
  assign out_unf    = out_unf_q;
  assign sticky_sat = sticky_q;
  assign sat_cnt    = cnt_q;

endmodule

// File: tb/tb_sat_accum_pipe.sv
// Scoreboard bench for sat_accum_pipe (WIDTH=8) with a CNT_W=2 twin for
// counter saturation.
module tb_sat_accum_pipe;
  import sat_pkg::*;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [1:0]   in_op;
  logic         out_ready;
  logic         clr_stat;

  logic         in_ready, out_valid, out_ovf, out_unf, sticky_sat;
  logic [W-1:0] out_res, acc_q;
  logic [7:0]   sat_cnt;

  logic         in_ready2, out_valid2, out_ovf2, out_unf2, sticky_sat2;
  logic [W-1:0] out_res2, acc_q2;
  logic [1:0]   sat_cnt2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int res;
    bit ovf;
    bit unf;
  } exp_t;

  exp_t q[$];
  int   acc_m    = 0;
  int   cnt_m    = 0;
  int   cnt2_m   = 0;
  bit   sticky_m = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sat_accum_pipe #(.WIDTH(W), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .out_ovf(out_ovf),
    .out_unf(out_unf), .acc_q(acc_q), .sticky_sat(sticky_sat),
    .sat_cnt(sat_cnt), .clr_stat(clr_stat)
  );

  sat_accum_pipe #(.WIDTH(W), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid2),
    .out_ready(out_ready), .out_res(out_res2), .out_ovf(out_ovf2),
    .out_unf(out_unf2), .acc_q(acc_q2), .sticky_sat(sticky_sat2),
    .sat_cnt(sat_cnt2), .clr_stat(clr_stat)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int x, input int y, input bit sub);
    exp_t e;
    int   r;
    r = sub ? (x - y) : (x + y);
    e.ovf = (r > 127);
    e.unf = (r < -128);
    e.res = e.ovf ? 127 : (e.unf ? -128 : r);
    return e;
  endfunction

  // Scoreboard: compare on output transfers, predict on input transfers.
  always @(negedge clk) begin
    exp_t e;
    bit   fire;
    if (!rst_n) begin
      q.delete();
      acc_m = 0; cnt_m = 0; cnt2_m = 0; sticky_m = 0;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_res", int'(out_res), 0);
      chk("rst_acc", int'(acc_q), 0);
      chk("rst_cnt", int'(sat_cnt), 0);
    end else begin
      chk("acc_q", int'($signed(acc_q)), acc_m);
      chk("sticky_sat", int'(sticky_sat), int'(sticky_m));
      chk("sat_cnt", int'(sat_cnt), cnt_m);
      chk("sat_cnt_w2", int'(sat_cnt2), cnt2_m);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = q.pop_front();
          chk("out_res", int'($signed(out_res)), e.res);
          chk("out_ovf", int'(out_ovf), int'(e.ovf));
          chk("out_unf", int'(out_unf), int'(e.unf));
        end
      end
      fire = in_valid && in_ready;
      e = '{0, 1'b0, 1'b0};
      if (fire) begin
        case (op_e'(in_op))
          OP_ADD: e = model(int'($signed(in_a)), int'($signed(in_b)), 1'b0);
          OP_SUB: e = model(int'($signed(in_a)), int'($signed(in_b)), 1'b1);
          OP_ACC: begin
            e = model(acc_m, int'($signed(in_a)), 1'b0);
            acc_m = e.res;
          end
          default: acc_m = 0;
        endcase
        q.push_back(e);
      end
      if (clr_stat) begin
        sticky_m = 0; cnt_m = 0; cnt2_m = 0;
      end else if (fire && (e.ovf || e.unf)) begin
        sticky_m = 1;
        if (cnt_m < 255) cnt_m++;
        if (cnt2_m < 3) cnt2_m++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input op_e op, input int a, input int b);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = W'(a);
    in_b     = W'(b);
    cyc();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    cyc();
  endtask

  initial begin
    int   held;
    rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    out_ready = 1'b1; clr_stat = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_sticky", int'(sticky_sat), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("ready_after_reset", int'(in_ready), 1);
    cyc();

    send(OP_ADD, 3, 3);
    chk("latency_valid", int'(out_valid), 1);
    chk("latency_res", int'($signed(out_res)), 6);
    send(OP_ADD, -127, -128);
    send(OP_ADD, 97, 96);
    idle();
    chk("cnt_after_adds", int'(sat_cnt), 2);
    chk("sticky_after_adds", int'(sticky_sat), 1);

    send(OP_SUB, 0, -128);
    send(OP_SUB, -128, 1);
    send(OP_SUB, 5, 7);
    idle();

    send(OP_CLR, 9, 9);
    send(OP_ACC, 100, 0);
    send(OP_ACC, 100, 0);
    chk("acc_chain_ovf", int'(out_ovf), 1);
    send(OP_ACC, -50, 0);
    idle();
    chk("acc_final", int'($signed(acc_q)), 77);
    send(OP_ADD, 1, 1);
    chk("add_keeps_acc_res", int'($signed(out_res)), 2);
    idle();
    chk("add_keeps_acc", int'($signed(acc_q)), 77);

    out_ready = 1'b0;
    send(OP_ADD, 10, 20);
    in_a = W'(1); in_b = W'(2);
    held = int'($signed(out_res));
    chk("bp_first_res", held, 30);
    repeat (5) begin
      chk("bp_ready_low", int'(in_ready), 0);
      chk("bp_hold_res", int'($signed(out_res)), 30);
      cyc();
    end
    out_ready = 1'b1;
    #1 chk("bp_ready_high", int'(in_ready), 1);
    cyc();
    chk("bp_next_res", int'($signed(out_res)), 3);
    idle();
    idle();

    clr_stat = 1'b1;
    idle();
    clr_stat = 1'b0;
    chk("clr_cnt", int'(sat_cnt), 0);
    repeat (5) send(OP_ADD, 100, 100);
    idle();
    chk("cnt_w2_cap", int'(sat_cnt2), 3);
    chk("cnt_w8_five", int'(sat_cnt), 5);
    clr_stat = 1'b1;
    send(OP_ADD, 100, 100);
    clr_stat = 1'b0;
    chk("clr_prio_cnt", int'(sat_cnt), 0);
    chk("clr_prio_cnt2", int'(sat_cnt2), 0);
    chk("clr_prio_sticky", int'(sticky_sat), 0);
    idle();

    send(OP_CLR, 0, 0);
    idle();
    out_ready = 1'b0;
    send(OP_ACC, 77, 0);
    in_valid = 1'b0;
    chk("pre_rst_valid", int'(out_valid), 1);
    chk("pre_rst_acc", int'($signed(acc_q)), 77);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_res", int'(out_res), 0);
    chk("async_rst_acc", int'(acc_q), 0);
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1 chk("post_rst_ready", int'(in_ready), 1);
    send(OP_ACC, 5, 0);
    chk("post_rst_acc_res", int'($signed(out_res)), 5);
    idle();

    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0 && !out_valid) break;
      idle();
    end
    chk("drain_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
